leftmost_one_index_sync: RTL and testbench

- Registered leading-one detector (priority encoder).
- Reports the bit position of the most-significant set bit of a WIDTH-bit input vector, with LSB = index 0.
- Used by the FMA normalizer to compute left-shift and exponent-adjust amounts.
- One clock, synchronous active-high reset, one-cycle latency. Includes a valid pipeline flag and an all-zero flag.

---
 rtl/leftmost_one_index_sync.sv | 58 +++++
 tb/tb_leftmost_one_index_sync.sv | 133 +++++++++++++
 2 files changed

// File: rtl/leftmost_one_index_sync.sv
// Registered leading-one detector: reports the index of the most-significant set
// bit of `in` (LSB = 0) one cycle later, with a valid flag and an all-zero flag.
module leftmost_one_index_sync #(
  parameter int WIDTH = 5,
  localparam int OW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  output logic [OW-1:0]    out,
  output logic             zero
);

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the
  // final value is the highest set index; an all-zero vector yields 0.
  function automatic logic [OW-1:0] lead_one_idx(input logic [WIDTH-1:0] v);
    logic [OW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = OW'(i);
    end
    return idx;
  endfunction

  logic          out_valid_d, out_valid_q;
  logic [OW-1:0] out_d, out_q;
  logic          zero_d, zero_q;

  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    zero_d      = zero_q;
    if (in_valid) begin
      out_d  = lead_one_idx(in);
      zero_d = ~|in;
    end
  end

  // ---- registered output stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_leftmost_one_index_sync.sv
// Directed and exhaustive checks of leftmost_one_index_sync at WIDTH=5 and WIDTH=8.
module tb_leftmost_one_index_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       v5, v8;
  logic [4:0] in5;
  logic [7:0] in8;
  logic       ov5, ov8, z5, z8;
  logic [2:0] o5, o8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  leftmost_one_index_sync #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in(in5),
    .out_valid(ov5), .out(o5), .zero(z5)
  );

  leftmost_one_index_sync #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in(in8),
    .out_valid(ov8), .out(o8), .zero(z8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: index of highest set bit found by repeated right shifts.
  function automatic int ref_idx(input logic [63:0] v);
    int idx;
    idx = 0;
    while (v > 64'd1) begin
      v = v >> 1;
      idx++;
    end
    return idx;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check5(input string tag, input logic exp_v, input int exp_o, input logic exp_z);
    check({tag, ".valid"}, 32'(ov5), 32'(exp_v));
    check({tag, ".out"},   32'(o5),  32'(exp_o));
    check({tag, ".zero"},  32'(z5),  32'(exp_z));
  endtask

  logic [4:0] dir_in [5];
  int         dir_exp [5];
  logic       vld;

  initial begin
    rst = 1'b1; v5 = 1'b1; in5 = 5'b10000; v8 = 1'b0; in8 = '0;
    dir_in  = '{5'b10000, 5'b00101, 5'b01111, 5'b00001, 5'b01000};
    dir_exp = '{4, 2, 3, 0, 3};

    // Reset held two cycles with a valid input present
    step(); check5("rst1", 1'b0, 0, 1'b1);
    step(); check5("rst2", 1'b0, 0, 1'b1);
    rst = 1'b0;
    step(); check5("first", 1'b1, 4, 1'b0);

    // Directed back-to-back vectors
    for (int i = 0; i < 5; i++) begin
      in5 = dir_in[i]; v5 = 1'b1;
      step(); check5($sformatf("dir%0d", i), 1'b1, dir_exp[i], 1'b0);
    end

    // All-zero input
    in5 = 5'b00000; v5 = 1'b1;
    step(); check5("zero_in", 1'b1, 0, 1'b1);

    // Streaming with a gap: outputs hold during the idle cycle
    in5 = 5'b10000; v5 = 1'b1; step(); check5("strm0", 1'b1, 4, 1'b0);
    in5 = 5'b00001; v5 = 1'b1; step(); check5("strm1", 1'b1, 0, 1'b0);
    in5 = 5'b11111; v5 = 1'b0; step(); check5("strm_gap", 1'b0, 0, 1'b0);
    in5 = 5'b01000; v5 = 1'b1; step(); check5("strm3", 1'b1, 3, 1'b0);

    // Reset on the same edge as a valid input discards it
    in5 = 5'b00101; v5 = 1'b1; rst = 1'b1;
    step(); check5("mid_rst", 1'b0, 0, 1'b1);
    rst = 1'b0; v5 = 1'b0;
    step(); check5("mid_rst_after", 1'b0, 0, 1'b1);

    // Exhaustive WIDTH=5 with periodic valid gaps
    for (int i = 0; i < 32; i++) begin
      vld = (i % 3) != 2;
      in5 = 5'(i); v5 = vld;
      step();
      check($sformatf("ex5_v%0d", i), 32'(ov5), 32'(vld));
      if (vld) begin
        check($sformatf("ex5_o%0d", i), 32'(o5), 32'(ref_idx(64'(i))));
        check($sformatf("ex5_z%0d", i), 32'(z5), 32'(i == 0));
      end
    end
    v5 = 1'b0;

    // Exhaustive WIDTH=8 with periodic valid gaps
    for (int i = 0; i < 256; i++) begin
      vld = (i % 5) != 4;
      in8 = 8'(i); v8 = vld;
      step();
      check($sformatf("ex8_v%0d", i), 32'(ov8), 32'(vld));
      if (vld) begin
        check($sformatf("ex8_o%0d", i), 32'(o8), 32'(ref_idx(64'(i))));
        check($sformatf("ex8_z%0d", i), 32'(z8), 32'(i == 0));
      end
    end

    // Top bit at WIDTH=8
    in8 = 8'h80; v8 = 1'b1;
    step();
    check("w8_msb.out",   32'(o8),  32'd7);
    check("w8_msb.valid", 32'(ov8), 32'd1);
    check("w8_msb.zero",  32'(z8),  32'd0);
    v8 = 1'b0;
    step();
    check("w8_idle.valid", 32'(ov8), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
